// File: rtl/rfphoenix_mem_responder.sv
// Memory responder: queues core requests, runs each one as 1 (scalar) or 4 (vect) 128-bit
// bus beats, and queues one tagged response per request, strictly in request order.

module rfphoenix_mem_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  // Full is taken from this cycle's count, so a pop never makes room for a same-cycle push.
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module rfphoenix_mem_responder #(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_wr,
  input  logic [1:0]   req_func,
  input  logic [1:0]   req_sz,
  input  logic [31:0]  req_adr,
  input  logic [511:0] req_dat,
  input  logic [3:0]   req_rid,
  input  logic [3:0]   req_step,
  output logic         req_full,
  output logic         req_wack,
  input  logic         resp_rd,
  output logic         resp_empty,
  output logic         resp_v,
  output logic [3:0]   resp_rid,
  output logic [3:0]   resp_step,
  output logic [511:0] resp_dat,
  output logic         resp_err,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [15:0]  sel_o,
  output logic [31:0]  adr_o,
  output logic [127:0] dat_o,
  input  logic [127:0] dat_i,
  input  logic         ack_i,
  input  logic         err_i
);
  localparam logic [1:0]  MR_LOAD  = 2'd0;
  localparam logic [1:0]  MR_STORE = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef struct packed {
    logic [1:0]   func;
    logic [1:0]   sz;
    logic [31:0]  adr;
    logic [511:0] dat;
    logic [3:0]   rid;
    logic [3:0]   step;
  } req_t;

  typedef struct packed {
    logic [3:0]   rid;
    logic [3:0]   step;
    logic         err;
    logic [511:0] dat;
  } rsp_t;

  typedef enum logic [2:0] {IDLE, CHK, BUS, NXT, RSP} state_t;

  state_t       state;
  req_t         req_in, req_head, cur;
  rsp_t         rsp_in, rsp_head;
  logic         req_empty, rsp_full, req_pop, rsp_push, rsp_pop;
  logic [1:0]   beat;
  logic [511:0] rdat;
  logic         err;
  logic [15:0]  tmo_cnt;
  logic         tmo_fire, is_vect, bad_req;
  logic [15:0]  lane_sel;

  function automatic logic [127:0] store_beat(input req_t r, input logic [1:0] b);
    logic [127:0] v;
    case (r.sz)
      2'd0:    v = {16{r.dat[7:0]}};
      2'd1:    v = {8{r.dat[15:0]}};
      2'd2:    v = {4{r.dat[31:0]}};
      default: v = r.dat[{b, 7'd0} +: 128];
    endcase
    return v;
  endfunction

  function automatic logic [31:0] load_ext(input req_t r, input logic [127:0] d);
    logic [127:0] s;
    logic         sgn;
    logic [31:0]  v;
    s   = d >> {r.adr[3:0], 3'b000};
    sgn = (r.func == MR_LOAD);
    case (r.sz)
      2'd0:    v = {{24{sgn & s[7]}}, s[7:0]};
      2'd1:    v = {{16{sgn & s[15]}}, s[15:0]};
      default: v = s[31:0];
    endcase
    return v;
  endfunction

  assign req_in  = '{func: req_func, sz: req_sz, adr: req_adr, dat: req_dat,
                     rid: req_rid, step: req_step};
  assign rsp_in  = '{rid: cur.rid, step: cur.step, err: err, dat: rdat};
  assign req_pop  = (state == IDLE) && !req_empty;
  assign rsp_push = (state == RSP) && !rsp_full;
  assign rsp_pop  = resp_rd && !resp_empty;

  rfphoenix_mem_fifo #(.W($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(req_wr), .push_dat(req_in), .pop(req_pop),
    .pop_dat(req_head), .full(req_full), .empty(req_empty));

  rfphoenix_mem_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(rsp_push), .push_dat(rsp_in), .pop(rsp_pop),
    .pop_dat(rsp_head), .full(rsp_full), .empty(resp_empty));

  assign is_vect  = (cur.sz == 2'd3);
  assign bad_req  = (cur.func == 2'd3) ||
                    ((cur.sz == 2'd1) && cur.adr[0]) ||
                    ((cur.sz == 2'd2) && (cur.adr[1:0] != 2'd0)) ||
                    (is_vect && (cur.adr[3:0] != 4'd0));
  assign tmo_fire = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    lane_sel = 16'hFFFF;
    case (cur.sz)
      2'd0:    lane_sel = 16'h0001 << cur.adr[3:0];
      2'd1:    lane_sel = 16'h0003 << cur.adr[3:0];
      2'd2:    lane_sel = 16'h000F << cur.adr[3:0];
      default: lane_sel = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_wack  <= 1'b0;
      resp_v    <= 1'b0;
      resp_rid  <= '0;
      resp_step <= '0;
      resp_err  <= 1'b0;
      resp_dat  <= '0;
    end else begin
      req_wack <= req_wr && !req_full;
      resp_v   <= rsp_pop;
      if (rsp_pop) begin
        resp_rid  <= rsp_head.rid;
        resp_step <= rsp_head.step;
        resp_err  <= rsp_head.err;
        resp_dat  <= rsp_head.dat;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cur     <= '0;
      beat    <= '0;
      rdat    <= '0;
      err     <= 1'b0;
      tmo_cnt <= '0;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
    end else begin
      case (state)
        IDLE: if (!req_empty) begin
          cur   <= req_head;
          state <= CHK;
        end
        CHK: begin
          beat <= '0;
          rdat <= '0;
          err  <= 1'b0;
          if (bad_req) begin
            err   <= 1'b1;
            state <= RSP;
          end else begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            we_o    <= (cur.func == MR_STORE);
            sel_o   <= lane_sel;
            adr_o   <= {cur.adr[31:4], 4'h0};
            dat_o   <= store_beat(cur, 2'd0);
            tmo_cnt <= '0;
            state   <= BUS;
          end
        end
        BUS: if (err_i || (!ack_i && tmo_fire)) begin
          // An abandoned beat kills the whole request, including earlier vect beats.
          err   <= 1'b1;
          rdat  <= '0;
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          state <= RSP;
        end else if (ack_i) begin
          if (cur.func != MR_STORE) begin
            if (is_vect) rdat[{beat, 7'd0} +: 128] <= dat_i;
            else         rdat <= {480'd0, load_ext(cur, dat_i)};
          end
          if (is_vect && (beat != 2'd3)) begin
            stb_o <= 1'b0;
            state <= NXT;
          end else begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            state <= RSP;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
        NXT: begin
          beat    <= beat + 1'b1;
          adr_o   <= adr_o + 32'd16;
          dat_o   <= store_beat(cur, beat + 1'b1);
          stb_o   <= 1'b1;
          tmo_cnt <= '0;
          state   <= BUS;
        end
        RSP: if (!rsp_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
